// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: owner encoding,
// default bus widths and the starvation counter width.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF   = 32;
  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned STARVE_CNT_W = 4;

  // Which requester owns the memory port in a given cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection for the shared memory port plus the fetch starvation
// counter. Data has fixed priority; fetch is forced through once it has
// watched STARVE_MAX consecutive data grants while it was waiting.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   arm                 grants allowed (low in the reset-release cycle)
//   if_req, if_flush    fetch request and flush
//   d_req               data request
//   if_gnt, d_gnt       combinational grants (mutually exclusive)
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arm,
  input  logic if_req,
  input  logic if_flush,
  input  logic d_req,
  output logic if_gnt,
  output logic d_gnt
);

  logic [STARVE_CNT_W-1:0] starve_cnt;
  logic                    if_ok;
  logic                    force_if;

  // Grant decision; a flushed fetch never competes.
  always_comb begin
    if_ok    = if_req & ~if_flush;
    force_if = if_ok & (starve_cnt == STARVE_CNT_W'(STARVE_MAX));
    d_gnt    = arm & d_req & ~force_if;
    if_gnt   = arm & if_ok & ~d_gnt;
  end

  // Counts data grants that overtook a waiting fetch, saturating at max.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (if_gnt || !if_ok) begin
      starve_cnt <= '0;
    end else if (d_gnt && (starve_cnt != STARVE_CNT_W'(STARVE_MAX))) begin
      starve_cnt <= starve_cnt + STARVE_CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported synchronous memory (1-cycle read latency)
// between instruction fetch and the data stages, and routes each read
// response back to the requester that issued it.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   if_req/if_addr/if_flush          fetch request side
//   if_gnt/if_rvalid/if_rdata        fetch grant and read response
//   d_req/d_we/d_addr/d_wdata/d_wstrb data request side
//   d_gnt/d_rvalid/d_rdata           data grant and load response
//   ram_en/ram_we/ram_addr/ram_wdata memory command
//   ram_rdata                        memory read data (cycle after read)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                ram_en,
  output logic [DATA_W/8-1:0] ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);

  logic   arm_q;
  logic   rsp_if_q;
  logic   rsp_d_q;
  owner_e own_c;

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk      (clk),
    .rst_n    (rst_n),
    .arm      (arm_q),
    .if_req   (if_req),
    .if_flush (if_flush),
    .d_req    (d_req),
    .if_gnt   (if_gnt),
    .d_gnt    (d_gnt)
  );

  // Holds off all grants in the first cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_q <= 1'b0;
    end else begin
      arm_q <= 1'b1;
    end
  end

  // Port owner this cycle.
  always_comb begin
    own_c = OWN_NONE;
    if (d_gnt) begin
      own_c = OWN_D;
    end else if (if_gnt) begin
      own_c = OWN_IF;
    end
  end

  // Memory command mux; only a granted store drives byte enables.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (own_c)
      OWN_D: begin
        ram_en    = 1'b1;
        ram_addr  = d_addr;
        ram_wdata = d_wdata;
        ram_we    = d_we ? d_wstrb : '0;
      end
      OWN_IF: begin
        ram_en   = 1'b1;
        ram_addr = if_addr;
      end
      default: begin
      end
    endcase
  end

  // Remembers who issued the read now in flight; stores return nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_if_q <= 1'b0;
      rsp_d_q  <= 1'b0;
    end else begin
      rsp_if_q <= if_gnt;
      rsp_d_q  <= d_gnt & ~d_we;
    end
  end

  // Response routing; a flush in the return cycle drops the stale fetch.
  always_comb begin
    d_rvalid  = rsp_d_q;
    d_rdata   = rsp_d_q ? ram_rdata : '0;
    if_rvalid = rsp_if_q & ~if_flush;
    if_rdata  = if_rvalid ? ram_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int unsigned STARVE_MAX = 4;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  mem_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_wstrb   (d_wstrb),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-only memory contents as a function of address.
  function automatic logic [31:0] rd(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory stub: synchronous read, one cycle latency.
  always @(posedge clk) begin
    if (ram_en && (ram_we == 4'h0)) ram_rdata <= rd(ram_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who owns the port, how long fetch has waited,
  // and which read is due back this cycle.
  logic        m_armed = 1'b0;
  int          m_waits = 0;
  int          m_rsp   = 0;     // 0 none, 1 fetch, 2 data
  logic [31:0] m_rsp_addr = '0;

  always @(negedge clk) begin
    logic want_if;
    int   g;                   // 0 none, 1 fetch, 2 data
    if (!rst_n) begin
      chk("rst_if_gnt", 32'(if_gnt), 32'd0);
      chk("rst_d_gnt", 32'(d_gnt), 32'd0);
      chk("rst_ram_en", 32'(ram_en), 32'd0);
      chk("rst_ram_we", 32'(ram_we), 32'd0);
      chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
      chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_d_rdata", d_rdata, 32'd0);
      m_armed = 1'b0;
      m_waits = 0;
      m_rsp   = 0;
    end else begin
      want_if = if_req && !if_flush;
      g = 0;
      if (m_armed) begin
        if (d_req && !(want_if && m_waits == int'(STARVE_MAX))) g = 2;
        else if (want_if) g = 1;
      end
      chk("if_gnt", 32'(if_gnt), (g == 1) ? 32'd1 : 32'd0);
      chk("d_gnt", 32'(d_gnt), (g == 2) ? 32'd1 : 32'd0);
      chk("ram_en", 32'(ram_en), (g != 0) ? 32'd1 : 32'd0);
      chk("ram_we", 32'(ram_we), (g == 2 && d_we) ? 32'(d_wstrb) : 32'd0);
      if (g == 1) begin
        chk("ram_addr_if", ram_addr, if_addr);
        chk("ram_wdata_if", ram_wdata, 32'd0);
      end else if (g == 2) begin
        chk("ram_addr_d", ram_addr, d_addr);
        chk("ram_wdata_d", ram_wdata, d_wdata);
      end
      if (m_rsp == 1 && !if_flush) begin
        chk("if_rvalid", 32'(if_rvalid), 32'd1);
        chk("if_rdata", if_rdata, rd(m_rsp_addr));
      end else begin
        chk("if_rvalid", 32'(if_rvalid), 32'd0);
        chk("if_rdata", if_rdata, 32'd0);
      end
      if (m_rsp == 2) begin
        chk("d_rvalid", 32'(d_rvalid), 32'd1);
        chk("d_rdata", d_rdata, rd(m_rsp_addr));
      end else begin
        chk("d_rvalid", 32'(d_rvalid), 32'd0);
        chk("d_rdata", d_rdata, 32'd0);
      end
      // Advance to the state after the coming clock edge.
      if (g == 1 || !want_if) m_waits = 0;
      else if (g == 2 && m_waits < int'(STARVE_MAX)) m_waits = m_waits + 1;
      m_rsp = 0;
      if (g == 1) begin
        m_rsp = 1;
        m_rsp_addr = if_addr;
      end else if (g == 2 && !d_we) begin
        m_rsp = 2;
        m_rsp_addr = d_addr;
      end
      m_armed = 1'b1;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req = 1'b0; if_flush = 1'b0; d_req = 1'b0; d_we = 1'b0; d_wstrb = 4'h0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    if_addr = '0; d_addr = '0; d_wdata = '0;
    ram_rdata = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset release with both requesters pending, then starvation pattern.
    if_req = 1'b1; if_addr = 32'h80;
    d_req = 1'b1; d_addr = 32'h40;
    rst_n = 1'b1;
    @(negedge clk);
    chk("arm_if_gnt", 32'(if_gnt), 32'd0);
    chk("arm_d_gnt", 32'(d_gnt), 32'd0);
    chk("arm_ram_en", 32'(ram_en), 32'd0);
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      d_addr = 32'h40 + 32'(4 * i);
      @(negedge clk);
      chk("pat_d_gnt", 32'(d_gnt), (i % 5 == 4) ? 32'd0 : 32'd1);
      chk("pat_if_gnt", 32'(if_gnt), (i % 5 == 4) ? 32'd1 : 32'd0);
      if (i == 0) chk("first_ram_addr", ram_addr, 32'h40);
    end
    next_cycle();
    idle();
    next_cycle();

    // Fetch-only read.
    if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    chk("fetch_gnt", 32'(if_gnt), 32'd1);
    chk("fetch_ram_addr", ram_addr, 32'h100);
    next_cycle();
    idle();
    @(negedge clk);
    chk("fetch_rvalid", 32'(if_rvalid), 32'd1);
    chk("fetch_rdata", if_rdata, 32'hDEAD_BEEF);
    chk("fetch_no_d_rvalid", 32'(d_rvalid), 32'd0);

    // Store.
    next_cycle();
    d_req = 1'b1; d_we = 1'b1; d_wstrb = 4'h3; d_addr = 32'h200; d_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("store_ram_we", 32'(ram_we), 32'h3);
    chk("store_ram_wdata", ram_wdata, 32'h1234_5678);
    next_cycle();
    idle();
    @(negedge clk);
    chk("store_no_rvalid", 32'(d_rvalid), 32'd0);

    // Stores against a waiting fetch count towards starvation too.
    next_cycle();
    if_req = 1'b1; if_addr = 32'h180;
    d_req = 1'b1; d_we = 1'b1; d_wstrb = 4'hF; d_wdata = 32'hCAFE_0000;
    for (int i = 0; i < 5; i++) begin
      d_addr = 32'h400 + 32'(4 * i);
      @(negedge clk);
      chk("st_pat_if_gnt", 32'(if_gnt), (i == 4) ? 32'd1 : 32'd0);
      next_cycle();
    end
    idle();
    next_cycle();

    // Fetch granted, then flushed in its return cycle with a load pending.
    if_req = 1'b1; if_addr = 32'h104;
    @(negedge clk);
    chk("flush_T_if_gnt", 32'(if_gnt), 32'd1);
    next_cycle();
    if_flush = 1'b1; d_req = 1'b1; d_addr = 32'h300;
    @(negedge clk);
    chk("flush_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("flush_if_gnt", 32'(if_gnt), 32'd0);
    chk("flush_d_gnt", 32'(d_gnt), 32'd1);
    next_cycle();
    idle();
    @(negedge clk);
    chk("flush_d_rvalid", 32'(d_rvalid), 32'd1);
    chk("flush_d_rdata", d_rdata, 32'h0300_FCFF);

    // Reset while a load is in flight.
    next_cycle();
    d_req = 1'b1; d_addr = 32'h44;
    @(negedge clk);
    chk("pre_rst_d_gnt", 32'(d_gnt), 32'd1);
    next_cycle();
    rst_n = 1'b0;
    idle();
    #1;
    chk("rst_drop_d_rvalid", 32'(d_rvalid), 32'd0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1; d_req = 1'b1; d_addr = 32'h48;
    @(negedge clk);
    chk("rearm_d_gnt0", 32'(d_gnt), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("rearm_d_gnt1", 32'(d_gnt), 32'd1);
    next_cycle();
    idle();
    repeat (3) next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported synchronous memory (1-cycle read latency) between two requesters: the instruction-fetch requester and the data requester (execute-stage loads, memory-stage stores).
- Data has fixed priority. A starvation counter forces a fetch grant after a bounded run of data grants.
- Tracks the owner of each in-flight read and routes the returned data to that owner.
- Supports a fetch flush on taken jumps and branches.
- Sits between the fetch/execute/memory stages and the unified memory macro.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width. Byte-strobe width is DATA_W/8.
- STARVE_MAX, 4, maximum consecutive data grants while fetch is waiting (legal range 1..15).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch read request
- if_addr  in  ADDR_W  fetch address
- if_flush  in  1  kill fetch traffic (taken jump/branch)
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DATA_W  fetch read data
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_wstrb  in  DATA_W/8  store byte enables
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid
- d_rdata  out  DATA_W  load data
- ram_en  out  1  memory access enable
- ram_we  out  DATA_W/8  memory byte write enables
- ram_addr  out  ADDR_W  memory address
- ram_wdata  out  DATA_W  memory write data
- ram_rdata  in  DATA_W  memory read data, valid the cycle after a read enable

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset values:
  - All registers clear: starve_cnt=0, rsp_if_q=0, rsp_d_q=0, arm_q=0.
  - Outputs during reset: if_gnt=0, d_gnt=0, if_rvalid=0, d_rvalid=0, rdata outputs=0, ram_en=0, ram_we=0.
- Arm register: arm_q sets to 1 on the first clock edge after reset release. Both grants are forced to 0 while arm_q=0, so no request is granted in the reset-release cycle.
- Grant (combinational, same cycle as request):
  - if_ok = if_req & ~if_flush
  - force_if = if_ok & (starve_cnt == STARVE_MAX)
  - d_gnt = arm_q & d_req & ~force_if
  - if_gnt = arm_q & if_ok & ~d_gnt
  - At most one grant per cycle.
- Memory drive:
  - ram_en = if_gnt | d_gnt.
  - ram_addr, ram_wdata and ram_we come from the granted requester.
  - ram_we = d_wstrb only when d_gnt & d_we; otherwise 0.
  - ram_wdata = 0 when the fetch requester is granted.
- Starvation counter:
  - Increments on d_gnt & if_ok, saturating at STARVE_MAX.
  - Clears on if_gnt, or whenever if_ok=0.
  - Otherwise holds.
- Response tracking (registered):
  - rsp_if_q <= if_gnt.
  - rsp_d_q <= d_gnt & ~d_we.
  - Stores produce no rvalid.
- Response outputs:
  - d_rvalid = rsp_d_q; d_rdata = rsp_d_q ? ram_rdata : 0.
  - if_rvalid = rsp_if_q & ~if_flush; if_rdata = if_rvalid ? ram_rdata : 0.
  - A flush in the return cycle kills the stale fetch response.
- Throughput: back-to-back accesses every cycle. Reads complete in exactly 1 cycle. No buffering and no outstanding limit beyond one access in flight per cycle.
- Simultaneous events:
  - Flush and request in the same cycle: the fetch is not granted, and a data request is still granted.
  - Flush on the same cycle as a fetch response suppresses only that response.
  - A store granted while the starvation counter is below max increments the counter the same way a load does.
- Reset mid-operation: in-flight responses are dropped (rvalid clears asynchronously). Requesters must reissue.
- Address handling: no alignment checks; addresses pass through unchanged.

Decomposition:
- Shared package (mem_arb_pkg):
  - Owner encoding OWN_NONE / OWN_IF / OWN_D.
  - Default ADDR_W / DATA_W.
  - STARVE_CNT_W = 4.
- One sub-module, mem_arb_pick: pure grant logic plus the starvation counter register.
- The top level holds the response-tracking registers, the arm register and the memory muxing.

Test Plan:
- Reset release with if_req=1 and d_req=1 held high: no grant in the first cycle (arm_q=0). Next cycle d_gnt=1; ram_en=1 with ram_addr=d_addr.
- Fetch-only read, if_addr=0x100, memory returns 0xDEADBEEF: if_gnt same cycle; if_rvalid=1 with if_rdata=0xDEADBEEF exactly one cycle later; d_rvalid stays 0.
- if_req and d_req held high continuously, STARVE_MAX=4: grant pattern D,D,D,D,IF repeating; starve_cnt returns to 0 after each IF grant.
- Store d_we=1, d_wstrb=0x3, d_addr=0x200, d_wdata=0x12345678: ram_we=0x3 for that cycle; no d_rvalid the following cycle.
- Fetch granted in cycle T, if_flush=1 in cycle T+1: if_rvalid=0 in T+1; no fetch grant in T+1; a concurrent load in T+1 is granted and returns in T+2.
- Assert rst_n=0 the cycle after a load grant: d_rvalid=0 immediately; after release, no grant until arm_q=1.
